tft_spi_rx_decoder: RTL and testbench
=====================================

Name: tft_spi_rx_decoder

Overview:
- Panel-side model of the TFT SPI link for screen simulation.
- Oversamples tft_clk/tft_cs/tft_mosi/tft_dc on the system clock and deserialises MSB-first bytes tagged with D/C.
- Decodes column-set (0x2A), page-set (0x2B) and memory-write (0x2C) to emit one (x, y, RGB565) pixel event per two data bytes, for the frame-buffer/dump logic in the simulation.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser (≥2).
- WIDTH, 240, panel columns; reset value of XE is WIDTH-1.
- HEIGHT, 320, panel rows; reset value of YE is HEIGHT-1.
- COORD_W, 9, width of pix_x/pix_y outputs.

Ports:
- clk  in  1  system clock; must be ≥4× tft_clk frequency.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- tft_mosi  in  1  serial data.
- tft_cs  in  1  chip select, active low.
- tft_dc  in  1  0 = command, 1 = data.
- tft_clk  in  1  serial clock; data sampled on rising edge.
- byte_data  out  8  last received byte.
- byte_dc  out  1  D/C of byte_data.
- byte_valid  out  1  one-cycle pulse, new byte.
- pix_x  out  COORD_W  pixel column.
- pix_y  out  COORD_W  pixel row.
- pix_rgb  out  16  RGB565 {hi, lo}.
- pix_valid  out  1  one-cycle pulse, pixel written.
- frame_err  out  1  one-cycle pulse, CS released mid-byte.

Behaviour:
- Reset (rst = 0, async): all outputs 0. Internal state cleared:
  - bit_cnt = 0; FSM = IDLE.
  - XS = 0, XE = WIDTH-1, YS = 0, YE = HEIGHT-1.
  - Cursor = (0, 0); synchroniser flops load idle levels (cs = 1, clk = 0, mosi = 1, dc = 0).
- Input path:
  - Each input passes through SYNC_STAGES flops.
  - sclk_rise = synced clk 1 this cycle and 0 the previous cycle.
- Deserialiser:
  - Active only while synced cs = 0.
  - On sclk_rise: shift in mosi MSB-first, bit_cnt += 1.
  - On the 8th rise: byte_data = {shift[6:0], mosi}, byte_dc = synced dc at that edge, byte_valid = 1 for exactly the next cycle, bit_cnt → 0.
  - Latency: byte_valid asserts SYNC_STAGES+1 clk cycles after the physical 8th rising edge.
- CS handling:
  - Synced cs = 1 forces bit_cnt = 0; sclk edges are ignored.
  - cs rising while bit_cnt ≠ 0: discard the partial byte, pulse frame_err once, emit no byte_valid.
  - cs may toggle between bytes or stay low across bytes; both are legal.
- Decoder FSM (states IDLE, CASET, PASET, RAMWR; driven by received bytes):
  - Any command byte (dc = 0) aborts the current state:
    - 0x2A → CASET, param idx 0.
    - 0x2B → PASET, param idx 0.
    - 0x2C → RAMWR; cursor = (XS, YS), phase = HI.
    - Any other value → IDLE.
  - CASET/PASET data bytes are collected in order S_hi, S_lo, E_hi, E_lo into a shadow register.
    - XS/XE (or YS/YE) update only when the 4th byte arrives.
    - Fewer than 4 bytes then a new command: start/end registers unchanged.
    - Bytes after the 4th are ignored; state is held.
  - RAMWR data bytes:
    - Phase HI: store byte; phase → LO.
    - Phase LO: pix_rgb = {hi, byte}, pix_x/pix_y = cursor (truncated to COORD_W), pix_valid pulsed the same cycle as that byte's byte_valid; phase → HI; cursor advances.
    - Advance rule: if x == XE then x = XS and (if y == YE then y = YS else y+1); otherwise x+1.
    - Odd trailing HI byte at command/abort is dropped; no pixel.
  - Data bytes in IDLE are ignored (byte_valid still pulses).
- Arithmetic: coordinates 16-bit internally; compare with equality only. If XS > XE, x increments to 16'hFFFF and wraps to 0 naturally; no special handling.
- Reset mid-byte or mid-pixel: everything cleared; no byte_valid, pix_valid or frame_err pulses are generated by the reset itself.

Test Plan:
- Send cmd 0x2A, data 00 05 00 06, cmd 0x2B, data 00 0A 00 0B, cmd 0x2C, data F8 00 07 E0 00 1F FF FF → pixels (5,10)=F800, (6,10)=07E0, (5,11)=001F, (6,11)=FFFF, then cursor wraps to (5,10).
- Single byte dc = 1, 0xA5 → byte_valid pulses exactly once, byte_data = A5, byte_dc = 1, SYNC_STAGES+1 cycles after the 8th tft_clk rise.
- Raise tft_cs after 5 bits, then send full byte 0x3C → one frame_err pulse, no byte for the partial, next byte_valid has byte_data = 3C.
- Cmd 0x2A with only 2 data bytes, then cmd 0x2C, data 12 34 → pixel at (0,0) = 1234 with XS/XE unchanged (0/239).
- After reset, cmd 0x2C, 2×240 pixels → pix_y goes 0→1 after x = 239; pix_x returns to 0.
- Assert rst low mid-RAMWR between HI and LO bytes, release, send data 56 78 → no pix_valid (FSM IDLE), byte_valid still pulses twice.

Source files
------------

// File: rtl/tft_spi_rx_decoder.sv
// Purpose: panel-side TFT SPI receiver; deserialises D/C-tagged bytes and decodes CASET/PASET/RAMWR into pixel events.
// Latency: byte_valid and pix_valid appear SYNC_STAGES+1 clk cycles after the 8th physical tft_clk rising edge.
// Backpressure: none; the panel always accepts, every output is a single-cycle pulse.
module tft_spi_rx_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int COORD_W     = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tft_mosi,
    input  logic               tft_cs,
    input  logic               tft_dc,
    input  logic               tft_clk,
    output logic [7:0]         byte_data,
    output logic               byte_dc,
    output logic               byte_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_rgb,
    output logic               pix_valid,
    output logic               frame_err
);

    localparam logic [15:0] XE_RST = 16'(WIDTH - 1);
    localparam logic [15:0] YE_RST = 16'(HEIGHT - 1);

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR
    } state_t;

    // Synchroniser chains; reset to the idle levels of the bus
    logic [SYNC_STAGES-1:0] sync_cs;
    logic [SYNC_STAGES-1:0] sync_clk;
    logic [SYNC_STAGES-1:0] sync_mosi;
    logic [SYNC_STAGES-1:0] sync_dc;
    logic                   clk_prev;

    logic s_cs;
    logic s_clk;
    logic s_mosi;
    logic s_dc;
    logic sclk_rise;

    // Deserialiser state
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       byte_stb;
    logic [7:0] rx_byte;

    // Decoder state
    state_t      state;
    logic [2:0]  pidx;
    logic [23:0] shadow;
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
    logic [15:0] cx;
    logic [15:0] cy;
    logic        phase_lo;
    logic [7:0]  hi_byte;

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_cs   <= '1;
            sync_clk  <= '0;
            sync_mosi <= '1;
            sync_dc   <= '0;
            clk_prev  <= 1'b0;
        end else begin
            sync_cs   <= {sync_cs[SYNC_STAGES-2:0], tft_cs};
            sync_clk  <= {sync_clk[SYNC_STAGES-2:0], tft_clk};
            sync_mosi <= {sync_mosi[SYNC_STAGES-2:0], tft_mosi};
            sync_dc   <= {sync_dc[SYNC_STAGES-2:0], tft_dc};
            clk_prev  <= sync_clk[SYNC_STAGES-1];
        end
    end

    assign s_cs      = sync_cs[SYNC_STAGES-1];
    assign s_clk     = sync_clk[SYNC_STAGES-1];
    assign s_mosi    = sync_mosi[SYNC_STAGES-1];
    assign s_dc      = sync_dc[SYNC_STAGES-1];
    assign sclk_rise = s_clk & ~clk_prev;

    // A full byte completes on the 8th rise while selected; the decoder consumes it in the same cycle
    assign byte_stb = ~s_cs & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte  = {shift, s_mosi};

    // Shift MSB-first while CS is low; releasing CS mid-byte discards the partial and flags it once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (s_cs) begin
                if (bit_cnt != 3'd0) begin
                    frame_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift   <= {shift[5:0], s_mosi};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_data  <= rx_byte;
                    byte_dc    <= s_dc;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    // Command decoder: window registers, RAMWR cursor and pixel emission
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pidx      <= '0;
            shadow    <= '0;
            xs        <= '0;
            xe        <= XE_RST;
            ys        <= '0;
            ye        <= YE_RST;
            cx        <= '0;
            cy        <= '0;
            phase_lo  <= 1'b0;
            hi_byte   <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (byte_stb) begin
                if (!s_dc) begin
                    // Any command aborts whatever was in progress, including a half pixel
                    pidx     <= '0;
                    phase_lo <= 1'b0;
                    case (rx_byte)
                        CMD_CASET: state <= ST_CASET;
                        CMD_PASET: state <= ST_PASET;
                        CMD_RAMWR: begin
                            state <= ST_RAMWR;
                            cx    <= xs;
                            cy    <= ys;
                        end
                        default:   state <= ST_IDLE;
                    endcase
                end else begin
                    case (state)
                        ST_CASET, ST_PASET: begin
                            if (pidx < 3'd3) begin
                                shadow <= {shadow[15:0], rx_byte};
                                pidx   <= pidx + 3'd1;
                            end else if (pidx == 3'd3) begin
                                // Window commits only once all four parameters have arrived
                                pidx <= 3'd4;
                                if (state == ST_CASET) begin
                                    xs <= shadow[23:8];
                                    xe <= {shadow[7:0], rx_byte};
                                end else begin
                                    ys <= shadow[23:8];
                                    ye <= {shadow[7:0], rx_byte};
                                end
                            end
                        end
                        ST_RAMWR: begin
                            if (!phase_lo) begin
                                hi_byte  <= rx_byte;
                                phase_lo <= 1'b1;
                            end else begin
                                phase_lo  <= 1'b0;
                                pix_rgb   <= {hi_byte, rx_byte};
                                pix_x     <= cx[COORD_W-1:0];
                                pix_y     <= cy[COORD_W-1:0];
                                pix_valid <= 1'b1;
                                if (cx == xe) begin
                                    cx <= xs;
                                    cy <= (cy == ye) ? ys : cy + 16'd1;
                                end else begin
                                    cx <= cx + 16'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tft_spi_rx_decoder.sv
// Purpose: scoreboard bench for tft_spi_rx_decoder driven by directed SPI byte sequences.
// Latency: expected bytes/pixels queued at stimulus time, popped by a monitor on each output pulse.
// Backpressure: none; the monitor flags any output pulse that has no queued expectation.
module tb_tft_spi_rx_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int COORD_W     = 9;

    logic               clk;
    logic               rst;
    logic               tft_mosi;
    logic               tft_cs;
    logic               tft_dc;
    logic               tft_clk;
    logic [7:0]         byte_data;
    logic               byte_dc;
    logic               byte_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [15:0]        pix_rgb;
    logic               pix_valid;
    logic               frame_err;

    tft_spi_rx_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (240),
        .HEIGHT     (320),
        .COORD_W    (COORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tft_mosi  (tft_mosi),
        .tft_cs    (tft_cs),
        .tft_dc    (tft_dc),
        .tft_clk   (tft_clk),
        .byte_data (byte_data),
        .byte_dc   (byte_dc),
        .byte_valid(byte_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .pix_valid (pix_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int fe_seen  = 0;
    bit chk_lat  = 1'b0;

    logic [8:0]  bq[$];   // {dc, data}
    logic [33:0] pq[$];   // {x, y, rgb}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every output pulse against the head of its queue
    always @(negedge clk) begin
        if (rst) begin
            if (byte_valid) begin
                if (bq.size() == 0) begin
                    check("byte_unexpected", {23'd0, byte_dc, byte_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = bq.pop_front();
                    check("byte_data", {24'd0, byte_data}, {24'd0, e[7:0]});
                    check("byte_dc", {31'd0, byte_dc}, {31'd0, e[8]});
                end
                if (chk_lat) begin
                    check("byte_latency", 32'(cyc - rise_cyc), 32'(SYNC_STAGES + 1));
                    chk_lat = 1'b0;
                end
            end
            if (pix_valid) begin
                if (pq.size() == 0) begin
                    check("pix_unexpected", {pix_x[7:0], pix_y[7:0], pix_rgb}, 32'hFFFF_FFFF);
                end else begin
                    logic [33:0] p;
                    p = pq.pop_front();
                    check("pix_x", 32'(pix_x), 32'(p[33:25]));
                    check("pix_y", 32'(pix_y), 32'(p[24:16]));
                    check("pix_rgb", 32'(pix_rgb), 32'(p[15:0]));
                end
            end
            if (frame_err) fe_seen++;
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        tft_dc = dc;
        tft_cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            tft_mosi = b[7-i];
            tft_clk  = 1'b0;
            repeat (2) @(negedge clk);
            tft_clk = 1'b1;
            if (i == 7) rise_cyc = cyc;
            repeat (2) @(negedge clk);
        end
        tft_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        bq.push_back({dc, b});
        send_bits(b, 8, dc);
    endtask

    task automatic cs_gap();
        tft_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic exp_pix(input int x, input int y, input logic [15:0] rgb);
        pq.push_back({9'(x), 9'(y), rgb});
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((bq.size() != 0 || pq.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drained"}, 32'(bq.size() + pq.size()), 32'd0);
    endtask

    task automatic do_reset();
        tft_cs   = 1'b1;
        tft_clk  = 1'b0;
        tft_mosi = 1'b1;
        tft_dc   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte", {23'd0, byte_valid, byte_dc, byte_data[6:0]}, 32'd0);
        check("rst_bdata", 32'(byte_data), 32'd0);
        check("rst_pix", {pix_valid, frame_err, pix_x[5:0], pix_y[7:0], pix_rgb}, 32'd0);
        check("rst_pixhi", {28'd0, pix_x[8:6], pix_y[8]}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        tft_cs   = 1'b1;
        tft_clk  = 1'b0;
        tft_mosi = 1'b1;
        tft_dc   = 1'b0;
        do_reset();

        // Window 5..6 x 10..11, four pixels then wrap back to the start
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
        cs_gap();
        send_byte(8'h2B, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
        send_byte(8'h2C, 1'b0);
        exp_pix(5, 10, 16'hF800); send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1);
        exp_pix(6, 10, 16'h07E0); send_byte(8'h07, 1'b1); send_byte(8'hE0, 1'b1);
        exp_pix(5, 11, 16'h001F); send_byte(8'h00, 1'b1); send_byte(8'h1F, 1'b1);
        exp_pix(6, 11, 16'hFFFF); send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        exp_pix(5, 10, 16'h1234); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        cs_gap();
        drain("window");

        // Single data byte with latency measurement; FSM returned to IDLE first
        send_byte(8'h00, 1'b0);
        cs_gap();
        chk_lat = 1'b1;
        send_byte(8'hA5, 1'b1);
        cs_gap();
        drain("single");
        check("lat_seen", {31'd0, chk_lat}, 32'd0);

        // Partial byte aborted by CS, then a clean byte
        send_bits(8'hFF, 5, 1'b1);
        cs_gap();
        send_byte(8'h3C, 1'b1);
        cs_gap();
        drain("partial");
        check("frame_err_count", 32'(fe_seen), 32'd1);

        // Short CASET leaves the default window
        do_reset();
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h2C, 1'b0);
        exp_pix(0, 0, 16'h1234); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        exp_pix(1, 0, 16'h5678); send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
        cs_gap();
        drain("short_caset");

        // Full-width rows: row advances after x = 239
        do_reset();
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 480; i++) begin
            exp_pix(i % 240, i / 240, 16'(i));
            send_byte(8'(i >> 8), 1'b1);
            send_byte(8'(i), 1'b1);
        end
        cs_gap();
        drain("rows");

        // Reset between HI and LO bytes of a pixel
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAB, 1'b1);
        cs_gap();
        drain("pre_reset");
        do_reset();
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        cs_gap();
        drain("post_reset");
        check("frame_err_final", 32'(fe_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
